uart_rx_cfg: RTL
================

UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter CLOCK_FREQUENCY, default 100_000_000: input clock rate in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600: line bit rate; CLOCKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE (integer division), legal only if >= 8.
REQ-003 SHALL have parameter DATA_BITS, default 8, legal 5..9: payload bits per frame, LSB first.
REQ-004 SHALL have parameter PARITY_MODE, default 0: 0 none, 1 odd, 2 even.
REQ-005 SHALL have parameter STOP_BITS, default 1, legal 1..2.
REQ-006 SHALL have ports: i_clk, input, 1, sole clock, all logic on its rising edge.
REQ-007 SHALL have port i_rst, input, 1, reset, synchronous and active-high.
REQ-008 SHALL have port i_rx_serial, input, 1, asynchronous serial line, idle high.
REQ-009 SHALL have port o_rx_data, output, DATA_BITS, received payload.
REQ-010 SHALL have port o_rx_valid, output, 1, o_rx_data and error flags valid.
REQ-011 SHALL have port i_rx_ready, input, 1, consumer accepts the word when high with o_rx_valid.
REQ-012 SHALL have ports o_parity_err and o_frame_err, output, 1 each, qualified by o_rx_valid.
REQ-013 SHALL have port o_overrun, output, 1, one-cycle pulse when a completed frame is dropped.

Function
REQ-014 SHALL pass i_rx_serial through a 2-flop synchronizer; all decisions use the synchronized line (2-cycle input latency).
REQ-015 SHALL sample each bit as the majority of three synchronized values taken at counts MID-1, MID, MID+1, where MID = CLOCKS_PER_BIT/2.
REQ-016 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-017 IDLE -> START on synchronized line low; the bit counter clears to 0.
REQ-018 In START, if the majority sample at MID+1 is high, it SHALL return to IDLE with no output (false start); otherwise it goes to DATA.
REQ-019 DATA SHALL take one majority sample per CLOCKS_PER_BIT cycles, aligned to start-bit mid, shifting LSB first; after DATA_BITS samples it goes to PARITY if PARITY_MODE != 0, else STOP.
REQ-020 PARITY SHALL flag a parity error if the XOR of the payload and the parity bit is 0 for odd mode or 1 for even mode.
REQ-021 STOP SHALL sample STOP_BITS bits; any stop-bit sample low sets the frame error.
REQ-022 After the last stop-bit sample, the FSM SHALL go to IDLE if the line is high, else to WAIT_IDLE (break/low line); WAIT_IDLE exits to IDLE only on a synchronized high line.
REQ-023 Frame completion (the cycle after the last stop-bit sample) SHALL load o_rx_data, o_parity_err and o_frame_err and set o_rx_valid, provided the output register is empty or being accepted in that same cycle.
REQ-024 o_rx_valid SHALL stay high, with data and flags stable, until a cycle with i_rx_ready high, then deassert next cycle unless a new frame loads simultaneously.
REQ-025 If a frame completes while o_rx_valid=1 and i_rx_ready=0, the new frame SHALL be discarded, the held word SHALL be kept, and o_overrun SHALL pulse for 1 cycle.
REQ-026 Reception SHALL continue independently of i_rx_ready (no backpressure to the line).
REQ-027 The bit counter SHALL be $clog2(CLOCKS_PER_BIT)+1 bits wide and SHALL never wrap within a bit period.

Reset
REQ-028 i_rst high SHALL force IDLE, clear counters and shift register, set o_rx_data=0, o_rx_valid=0, o_parity_err=0, o_frame_err=0, o_overrun=0, and preset the synchronizer to 1.
REQ-029 Reset asserted mid-frame SHALL abandon the frame with no output; after release the block SHALL re-arm on the next falling edge.

Structure
REQ-030 The FSM state encoding and PARITY_MODE constants (PARITY_NONE, PARITY_ODD, PARITY_EVEN) SHALL reside in shared package uart_pkg.
REQ-031 The synchronizer plus 3-sample majority logic SHALL be sub-module uart_rx_sampler, reusable by future receivers.

Verification (bench: CLOCK_FREQUENCY=16_000_000, BAUD_RATE=1_000_000, CLOCKS_PER_BIT=16)
REQ-032 8N1, send 0xA5, i_rx_ready=1 -> o_rx_valid for 1 cycle, o_rx_data=0xA5, both error flags 0.
REQ-033 DATA_BITS=7, even parity, send 0x03 with parity bit 1 -> o_rx_data=0x03, o_parity_err=1, o_frame_err=0.
REQ-034 8N2, second stop bit low, then line held low for 40 bit times -> o_frame_err=1 and no further o_rx_valid until the line has returned high and a new frame is sent.
REQ-035 Line low for 4 cycles, then high -> no o_rx_valid and FSM back in IDLE; a 1-cycle glitch at data-bit mid in 0x5A -> still receives 0x5A.
REQ-036 i_rx_ready=0, send 0x11 then 0x22 back to back -> o_rx_data holds 0x11, o_overrun pulses once; raising i_rx_ready clears o_rx_valid the next cycle.
REQ-037 Assert i_rst during data bit 4 of 0xFF -> no output; then send 0x3C -> 0x3C received cleanly.

Source files
------------

// File: rtl/uart_pkg.sv
// ============================================================================
// Module : uart_pkg
// Brief  : Shared UART receiver state encoding, parity modes, helpers
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_IDLE = 3'd5
  } uart_rx_state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_sampler.sv
// ============================================================================
// Module : uart_rx_sampler
// Brief  : 2-flop line synchronizer plus 3-sample majority of the synced line
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx_sampler
  import uart_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_rx_serial,
  output logic o_line,
  output logic o_majority
);

  logic       r_meta;
  logic       r_sync;
  logic [1:0] r_hist;

  // Presets to the idle (high) level so reset never looks like a start bit
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_hist <= 2'b11;
    end else begin
      r_meta <= i_rx_serial;
      r_sync <= r_meta;
      r_hist <= {r_hist[0], r_sync};
    end
  end

  assign o_line     = r_sync;
  assign o_majority = maj3(r_sync, r_hist[0], r_hist[1]);

endmodule

`default_nettype wire

// File: rtl/uart_rx_cfg.sv
// ============================================================================
// Module : uart_rx_cfg
// Brief  : Configurable UART receiver with held output word and overrun flag
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE       = 9600,
  parameter int DATA_BITS       = 8,
  parameter int PARITY_MODE     = 0,
  parameter int STOP_BITS       = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rx_serial,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_valid,
  input  logic                 i_rx_ready,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_overrun
);

  localparam int c_CLOCKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int c_MID            = c_CLOCKS_PER_BIT / 2;
  localparam int c_CNT_W          = $clog2(c_CLOCKS_PER_BIT) + 1;

  localparam logic [c_CNT_W-1:0] c_CNT_LAST   = c_CNT_W'(c_CLOCKS_PER_BIT - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_SAMPLE = c_CNT_W'(c_MID + 1);
  localparam logic [3:0]         c_LAST_DATA  = 4'(DATA_BITS - 1);
  localparam logic [3:0]         c_LAST_STOP  = 4'(STOP_BITS - 1);

  logic w_line;
  logic w_maj;
  logic w_sample;
  logic w_par_xor;

  uart_rx_state_t       r_state;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [3:0]           r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_err;
  logic                 r_frame_err;
  logic                 r_done;

  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_perr_q;
  logic                 r_ferr_q;
  logic                 r_overrun;

  uart_rx_sampler u_sampler (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_rx_serial (i_rx_serial),
    .o_line      (w_line),
    .o_majority  (w_maj)
  );

  // The counter free-runs across bit boundaries, so every later bit is
  // sampled at the same phase as the start-bit majority decision.
  assign w_sample  = (r_cnt == c_CNT_SAMPLE);
  assign w_par_xor = (^r_shift) ^ w_maj;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_par_err   <= 1'b0;
      r_frame_err <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE || r_state == S_WAIT_IDLE || r_cnt == c_CNT_LAST) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (!w_line) begin
            r_state     <= S_START;
            r_bit_idx   <= '0;
            r_par_err   <= 1'b0;
            r_frame_err <= 1'b0;
          end
        end
        S_START: begin
          if (w_sample) begin
            r_state <= w_maj ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (w_sample) begin
            r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
            if (r_bit_idx == c_LAST_DATA) begin
              r_bit_idx <= '0;
              r_state   <= (PARITY_MODE != PARITY_NONE) ? S_PARITY : S_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (w_sample) begin
            r_par_err <= (PARITY_MODE == PARITY_ODD) ? ~w_par_xor : w_par_xor;
            r_state   <= S_STOP;
          end
        end
        S_STOP: begin
          if (w_sample) begin
            if (!w_maj) begin
              r_frame_err <= 1'b1;
            end
            if (r_bit_idx == c_LAST_STOP) begin
              r_bit_idx <= '0;
              r_done    <= 1'b1;
              r_state   <= w_line ? S_IDLE : S_WAIT_IDLE;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end
        end
        S_WAIT_IDLE: begin
          if (w_line) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Single-entry output register; a completed frame that finds it full and
  // not being drained is dropped and reported as an overrun.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_perr_q  <= 1'b0;
      r_ferr_q  <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (r_done && (!r_valid || i_rx_ready)) begin
        r_data   <= r_shift;
        r_perr_q <= r_par_err;
        r_ferr_q <= r_frame_err;
        r_valid  <= 1'b1;
      end else begin
        if (r_done) begin
          r_overrun <= 1'b1;
        end
        if (r_valid && i_rx_ready) begin
          r_valid <= 1'b0;
        end
      end
    end
  end

  assign o_rx_data    = r_data;
  assign o_rx_valid   = r_valid;
  assign o_parity_err = r_perr_q;
  assign o_frame_err  = r_ferr_q;
  assign o_overrun    = r_overrun;

endmodule

`default_nettype wire
